// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a FIFO in fixed-length bursts onto a valid/ready stream.
// Define FIFO_RD_TIMEOUT_EN to pad a stalled burst with PAD_VALUE beats after TIMEOUT_CYC cycles.
module fifo_burst_reader #(
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 32,
  parameter int PAD_VALUE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_read_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_pad,
  output logic              busy,
  output logic              low_water,
  output logic [15:0]       burst_cnt
);
  localparam int EW = DATA_W + 2;
  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);
  typedef enum logic [1:0] {
    IDLE,
`ifdef FIFO_RD_TIMEOUT_EN
    PAD,
`endif
    BURST
  } state_t;
  state_t state_q, state_d;
  logic [7:0] beats_q, beats_d;
  logic inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic low_water_q, low_water_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic pop, credit, push, push_last, push_pad;
  logic [DATA_W-1:0] push_data;
`ifdef FIFO_RD_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYC, PAD_VALUE};
`endif
  assign m_valid = occ_q != 2'd0;
  assign {m_data, m_last, m_pad} = mem_q[rd_ptr_q];
  assign busy = state_q != IDLE || m_valid;
  assign low_water = low_water_q;
  assign burst_cnt = burst_cnt_q;
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    mem_d = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop = m_valid && m_ready;
    // reads in flight reserve a buffer slot so the 2-entry buffer cannot overflow
    credit = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop} < 3'd2;
    fifo_read_en = state_q == BURST && !fifo_empty && beats_q < 8'(BURST_LEN) && credit;
    inflight_d = fifo_read_en;
    inflight_last_d = beats_q == LAST_IDX;
    push = inflight_q;
    push_data = fifo_rdata;
    push_last = inflight_last_q;
    push_pad = 1'b0;
    if (state_q == IDLE && !fifo_empty) begin
      state_d = BURST;
      beats_d = 8'd0;
    end
    if (fifo_read_en) begin
      beats_d = beats_q + 8'd1;
      state_d = beats_q == LAST_IDX ? IDLE : state_q;
    end
`ifdef FIFO_RD_TIMEOUT_EN
    timer_d = state_q != BURST || fifo_read_en ? 16'd0 :
              fifo_empty && beats_q != 8'd0 ? timer_q + 16'd1 : timer_q;
    if (state_q == BURST && !fifo_read_en && timer_q >= 16'(TIMEOUT_CYC)) state_d = PAD;
    if (state_q == PAD && credit && !inflight_q) begin
      push = 1'b1;
      push_data = DATA_W'(PAD_VALUE);
      push_last = beats_q == LAST_IDX;
      push_pad = 1'b1;
      beats_d = beats_q + 8'd1;
      state_d = beats_q == LAST_IDX ? IDLE : PAD;
    end
`endif
    if (push) begin
      mem_d[wr_ptr_q] = {push_data, push_last, push_pad};
      wr_ptr_d = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    low_water_d = fifo_almost_empty;
    burst_cnt_d = burst_cnt_q + {15'd0, pop && m_last};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beats_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      mem_q <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q <= '0;
      low_water_q <= 1'b0;
      burst_cnt_q <= '0;
`ifdef FIFO_RD_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      inflight_q <= inflight_d;
      inflight_last_q <= inflight_last_d;
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q <= occ_d;
      low_water_q <= low_water_d;
      burst_cnt_q <= burst_cnt_d;
`ifdef FIFO_RD_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and randomized checks of fifo_burst_reader against a
// stream-level model (FIFO order, last on every BURST_LEN-th beat, padding on timeout).
module tb_fifo_burst_reader;
  localparam int BL = 4;
  localparam int TO = 8;
  localparam logic [7:0] PADV = 8'h00;
  logic clk = 1'b0, reset = 1'b1, fifo_empty = 1'b1, fifo_almost_empty = 1'b1, m_ready = 1'b0;
  logic [7:0] fifo_rdata = 8'h00;
  logic fifo_read_en, m_valid, m_last, m_pad, busy, low_water;
  logic [7:0] m_data;
  logic [15:0] burst_cnt;
  typedef struct packed {logic [7:0] d; logic l; logic p;} beat_t;
  logic [7:0] fq[$];
  beat_t exp_q[$];
  int rdq[$];
  int checks = 0, failures = 0, nwr = 0, nrd = 0, cyc_n = 0, exp_bcnt = 0;
  logic chk_lat = 1'b0, hold_prev = 1'b0, ae_prev = 1'b1, rst_edge = 1'b1;
  beat_t prev_beat = '0;

  fifo_burst_reader #(.DATA_W(8), .BURST_LEN(BL), .TIMEOUT_CYC(TO), .PAD_VALUE(0)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_rdata(fifo_rdata), .fifo_read_en(fifo_read_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_pad(m_pad), .busy(busy), .low_water(low_water),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic upd();
    fifo_empty = fq.size() == 0;
    fifo_almost_empty = fq.size() <= 1;
  endtask

  task automatic wr(input logic [7:0] d);
    fq.push_back(d);
    exp_q.push_back('{d: d, l: (nwr % BL) == BL - 1, p: 1'b0});
    nwr++;
    upd();
  endtask

  // one clock cycle: check outputs at the falling edge, then model the FIFO's registered read
  task automatic cyc();
    beat_t cur, e;
    logic rd;
    @(negedge clk);
    rd = fifo_read_en;
    cur = '{d: m_data, l: m_last, p: m_pad};
    chk("read_while_empty", 32'(fifo_read_en && fifo_empty), 0);
    chk("burst_cnt", 32'(burst_cnt), exp_bcnt);
    chk("low_water", 32'(low_water), (reset || rst_edge) ? 32'd0 : 32'(ae_prev));
    if (hold_prev) begin
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_beat", 32'(cur), 32'(prev_beat));
    end
    if (rd) nrd++;
    if (rd && chk_lat) rdq.push_back(cyc_n);
    if (m_valid && m_ready) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_data", 32'(cur.d), 32'(e.d));
        chk("m_last", 32'(cur.l), 32'(e.l));
        chk("m_pad", 32'(cur.p), 32'(e.p));
        if (e.l) exp_bcnt++;
        if (chk_lat && rdq.size() != 0) chk("latency", cyc_n - rdq.pop_front(), 2);
      end
    end
    hold_prev = m_valid && !m_ready && !reset;
    prev_beat = cur;
    @(posedge clk);
    ae_prev = fifo_almost_empty;
    rst_edge = reset;
    #1;
    cyc_n++;
    if (rd && fq.size() != 0) fifo_rdata = fq.pop_front();
    upd();
  endtask

  task automatic run_to(input int left, input int max, input bit rnd, input string tag);
    int n = 0;
    while (exp_q.size() > left && n < max) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    chk(tag, exp_q.size(), left);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fq.delete();
    exp_q.delete();
    rdq.delete();
    nwr = 0;
    exp_bcnt = 0;
    hold_prev = 1'b0;
    upd();
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_read_en", 32'(fifo_read_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_pad", 32'(m_pad), 0);
    chk("rst_low_water", 32'(low_water), 0);
    chk("rst_burst_cnt", 32'(burst_cnt), 0);
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    @(posedge clk);
    #1;
    do_reset();
    cyc();
    chk("idle_busy", 32'(busy), 0);
    // full burst with ready held high: 1 beat/cycle, 2-cycle read-to-valid latency
    m_ready = 1'b1;
    chk_lat = 1'b1;
    nrd = 0;
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i));
    run_to(0, 20, 1'b0, "t2_drain");
    chk_lat = 1'b0;
    cyc();
    cyc();
    chk("t2_reads", nrd, 4);
    chk("t2_burst_cnt", 32'(burst_cnt), 1);
    chk("t2_busy", 32'(busy), 0);
    // downstream backpressure limits outstanding reads to the buffer depth
    m_ready = 1'b0;
    nrd = 0;
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i));
    n = 0;
    while (!m_valid && n < 20) begin cyc(); n++; end
    chk("t3_valid_seen", 32'(m_valid), 1);
    repeat (6) cyc();
    chk("t3_reads_held", 32'(nrd <= 2), 1);
    m_ready = 1'b1;
    run_to(0, 20, 1'b0, "t3_drain");
    // FIFO runs dry mid-burst: burst stays open, completes when data returns
    wr(8'h20);
    wr(8'h21);
    run_to(0, 20, 1'b0, "t4_first_half");
    chk("t4_open_busy", 32'(busy), 1);
    chk("t4_open_valid", 32'(m_valid), 0);
    wr(8'h22);
    wr(8'h23);
    run_to(0, 20, 1'b0, "t4_second_half");
    cyc();
    cyc();
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_burst_cnt", 32'(burst_cnt), 3);
    for (int r = 0; r < 8; r++) begin
      n = BL * int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
        wr(8'($urandom));
`ifndef FIFO_RD_TIMEOUT_EN
        repeat ($urandom_range(0, 3)) begin
          m_ready = 1'($urandom_range(0, 1));
          cyc();
        end
`endif
      end
      run_to(0, 400, 1'b1, "rand_drain");
    end
    m_ready = 1'b1;
    cyc();
    cyc();
    chk("rand_idle_busy", 32'(busy), 0);
    // single entry then starvation
    wr(8'hAA);
    run_to(0, 20, 1'b0, "t5_data");
`ifdef FIFO_RD_TIMEOUT_EN
    repeat (TO) begin
      chk("t5_stall_quiet", 32'(m_valid), 0);
      cyc();
    end
    for (int i = 0; i < BL - 1; i++) exp_q.push_back('{d: PADV, l: i == BL - 2, p: 1'b1});
    nwr += BL - 1;
    run_to(0, 20, 1'b0, "t5_pads");
    cyc();
    chk("t5_busy", 32'(busy), 0);
`else
    repeat (20) begin
      chk("t5_open_quiet", 32'(m_valid), 0);
      cyc();
    end
    chk("t5_open_busy", 32'(busy), 1);
    chk("t5_no_read", 32'(fifo_read_en), 0);
`endif
    // reset in the middle of a burst, then a clean burst from beat 0
    do_reset();
    for (int i = 0; i < 4; i++) wr(8'h50 + 8'(i));
    run_to(2, 20, 1'b0, "t6_two_beats");
    do_reset();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_burst_cnt", 32'(burst_cnt), 0);
    for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
    run_to(0, 20, 1'b0, "t6_drain");
    cyc();
    chk("t6_burst_cnt_after", 32'(burst_cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
